sd_cmd_tx: RTL

Serializer for SD CMD-line command tokens, directly upstream of and feeding the CRC7 generator (sd_crc_7).
- Accepts command index and argument from the SD controller.
- Shifts the 48-bit token onto the CMD line, one bit per SD clock strobe, MSB first.
- Feeds the first 40 bits through sd_crc_7, then appends the CRC7 and the end bit.
- Drives the pad output-enable and signals completion to the controller.

---
 rtl/sd_cmd_tx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_tx.sv
// rtl/sd_cmd_tx.sv - SD CMD-line token serializer with CRC7 (optional NCC tail: SD_CMD_TX_NCC_EN)

// Serial CRC7 (x^7 + x^3 + 1), MSB-first input, cleared before each token
module sd_crc_7 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       shift_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic       fb;

  assign fb    = bit_i ^ crc_q[6];
  assign crc_o = crc_q;

  // CRC register: clear wins over shift; holds otherwise
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= 7'h00;
    end else if (clear_i) begin
      crc_q <= 7'h00;
    end else if (shift_i) begin
      crc_q <= {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
  end

endmodule

module sd_cmd_tx
`ifdef SD_CMD_TX_NCC_EN
  #(parameter int unsigned NCC_BITS = 8)
`endif
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sd_strobe,
  input  logic        i_start,
  input  logic [5:0]  i_cmd_index,
  input  logic [31:0] i_cmd_arg,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_sd_cmd_oe,
  output logic        o_sd_cmd_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_CRC,
    S_END,
`ifdef SD_CMD_TX_NCC_EN
    S_NCC,
`endif
    S_RELEASE
  } state_t;

  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic        oe_q;
  logic        out_q;
  logic [5:0]  cnt_q;
  logic [39:0] shift_q;
  logic [6:0]  crc_sh_q;
  logic [6:0]  crc_w;
  logic        accept;
  logic        crc_shift;
  logic [6:0]  crc_src;

`ifdef SD_CMD_TX_NCC_EN
  localparam int NCC_CW = $clog2(NCC_BITS + 1);
  logic [NCC_CW-1:0] ncc_cnt_q;
`endif

  // A start is only taken in IDLE with busy low; busy stays high through the
  // done cycle so a start coincident with o_done is dropped.
  assign accept    = (state_q == S_IDLE) && !busy_q && i_start;
  assign crc_shift = (state_q == S_DATA) && i_sd_strobe;

  // The CRC register stops moving once DATA ends, so its value is taken
  // directly on the first CRC strobe and the local copy is used afterwards.
  assign crc_src   = (cnt_q == 6'd0) ? crc_w : crc_sh_q;

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_sd_cmd_oe  = oe_q;
  assign o_sd_cmd_out = out_q;

  sd_crc_7 u_crc (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .clear_i (accept),
    .shift_i (crc_shift),
    .bit_i   (shift_q[39]),
    .crc_o   (crc_w)
  );

  // Token FSM with registered pad and handshake outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      oe_q      <= 1'b0;
      out_q     <= 1'b1;
      cnt_q     <= 6'd0;
      shift_q   <= 40'd0;
      crc_sh_q  <= 7'd0;
`ifdef SD_CMD_TX_NCC_EN
      ncc_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (done_q) begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
          end else if (accept) begin
            shift_q <= {2'b01, i_cmd_index, i_cmd_arg};
            busy_q  <= 1'b1;
            cnt_q   <= 6'd0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (i_sd_strobe) begin
            oe_q    <= 1'b1;
            out_q   <= shift_q[39];
            shift_q <= {shift_q[38:0], 1'b0};
            if (cnt_q == 6'd39) begin
              cnt_q   <= 6'd0;
              state_q <= S_CRC;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        S_CRC: begin
          if (i_sd_strobe) begin
            out_q    <= crc_src[6];
            crc_sh_q <= {crc_src[5:0], 1'b0};
            if (cnt_q == 6'd6) begin
              cnt_q   <= 6'd0;
              state_q <= S_END;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        S_END: begin
          if (i_sd_strobe) begin
            out_q <= 1'b1;
`ifdef SD_CMD_TX_NCC_EN
            ncc_cnt_q <= '0;
            state_q   <= S_NCC;
`else
            state_q <= S_RELEASE;
`endif
          end
        end
`ifdef SD_CMD_TX_NCC_EN
        S_NCC: begin
          if (i_sd_strobe) begin
            out_q <= 1'b1;
            if (ncc_cnt_q == NCC_CW'(NCC_BITS - 1)) begin
              state_q <= S_RELEASE;
            end else begin
              ncc_cnt_q <= ncc_cnt_q + 1'b1;
            end
          end
        end
`endif
        S_RELEASE: begin
          if (i_sd_strobe) begin
            oe_q    <= 1'b0;
            out_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
